// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM receiver: CIC order, register width
// and the saturating narrowing used on the decimated output.
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int SETTLE_N  = 3;

  function automatic int cic_width(input int log2_osr);
    return CIC_ORDER * log2_osr + 2;
  endfunction

  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock divider, per-bit sample strobe and the two-flop synchronizer
// that brings the asynchronous PDM data into the clk domain.
module pdm_clkgen #(
  parameter int CLKDIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic pdm_in,
  output logic pdm_clk,
  output logic smp,
  output logic pdm_bit
);

  localparam int CW = $clog2(CLKDIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pdm_clk_q, pdm_clk_d;
  logic [1:0]    sync_q;

  assign smp     = en && (cnt_q == CW'(CLKDIV - 1));
  assign pdm_clk = pdm_clk_q;
  assign pdm_bit = sync_q[1];

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CW'(CLKDIV - 1))) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered so the bit clock leaving the chip is glitch-free.
    pdm_clk_d = (cnt_d >= CW'(CLKDIV / 2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      sync_q    <= {sync_q[0], pdm_in};
    end
  end

endmodule

// File: rtl/pdm_cic_rx.sv
// PDM receiver: 3rd-order CIC decimator with settling suppression and a
// valid/ready output register that flags overwritten samples.
module pdm_cic_rx
  import pdm_pkg::*;
#(
  parameter int CLKDIV   = 8,
  parameter int LOG2_OSR = 6,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          pdm_clk,
  input  logic          pdm_in,
  output logic [DW-1:0] pcm_data,
  output logic          pcm_valid,
  input  logic          pcm_ready,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam int W     = cic_width(LOG2_OSR);
  localparam int SHIFT = CIC_ORDER * LOG2_OSR + 1 - DW;

  logic smp, pdm_bit;

  pdm_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .pdm_in  (pdm_in),
    .pdm_clk (pdm_clk),
    .smp     (smp),
    .pdm_bit (pdm_bit)
  );

  logic signed [W-1:0] integ_q [CIC_ORDER];
  logic signed [W-1:0] integ_d [CIC_ORDER];
  logic signed [W-1:0] dly_q   [CIC_ORDER];
  logic signed [W-1:0] dly_d   [CIC_ORDER];
  logic signed [W-1:0] comb_q, comb_d, x, acc, diff, scaled;
  logic [LOG2_OSR-1:0] phase_q, phase_d;
  logic [1:0]          settle_q, settle_d;
  logic                dec_q, dec_d, ld_q, ld_d;
  logic [DW-1:0]       pcm_data_q, pcm_data_d;
  logic                pcm_valid_q, pcm_valid_d, overrun_q, overrun_d;
  logic                load, accept;

  assign x      = pdm_bit ? W'(1) : '1;
  assign scaled = comb_q >>> SHIFT;
  assign accept = pcm_valid_q && pcm_ready;
  assign load   = en && ld_q && (settle_q == 2'(SETTLE_N));

  always_comb begin
    integ_d = integ_q;
    dly_d   = dly_q;
    comb_d  = comb_q;
    acc     = x;
    diff    = integ_q[CIC_ORDER-1];
    for (int i = 0; i < CIC_ORDER; i++) begin
      acc = integ_q[i] + acc;
      if (smp) integ_d[i] = acc;
    end
    // Wrap-around differences recover the true output as long as it fits in W bits.
    for (int i = 0; i < CIC_ORDER; i++) begin
      if (dec_q) dly_d[i] = diff;
      diff = diff - dly_q[i];
    end
    if (dec_q) comb_d = diff;
    if (!en) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_d[i] = '0;
        dly_d[i]   = '0;
      end
      comb_d = '0;
    end
  end

  always_comb begin
    phase_d     = smp ? phase_q + 1'b1 : phase_q;
    dec_d       = smp && (&phase_q);
    ld_d        = dec_q;
    settle_d    = (ld_q && (settle_q != 2'(SETTLE_N))) ? settle_q + 2'd1 : settle_q;
    pcm_data_d  = load ? DW'(sat(32'(scaled), DW)) : pcm_data_q;
    pcm_valid_d = load || (pcm_valid_q && !accept);
    overrun_d   = (load && pcm_valid_q && !pcm_ready) || (overrun_q && !ovr_clr);
    if (!en) begin
      phase_d     = '0;
      dec_d       = 1'b0;
      ld_d        = 1'b0;
      settle_d    = '0;
      pcm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      comb_q      <= '0;
      phase_q     <= '0;
      settle_q    <= '0;
      dec_q       <= 1'b0;
      ld_q        <= 1'b0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      dly_q       <= dly_d;
      comb_q      <= comb_d;
      phase_q     <= phase_d;
      settle_q    <= settle_d;
      dec_q       <= dec_d;
      ld_q        <= ld_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_rx.sv
// Directed bench for pdm_cic_rx: a PDM source driven off pdm_clk and a linear
// sequence of steps with hand-computed expected values.
module tb_pdm_cic_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        pdm_in = 1'b0;
  logic        pcm_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        pdm_clk, pcm_valid, overrun;
  logic [15:0] pcm_data;

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  int bit_idx = 0;
  int lat, cyc, hi, lo, d;

  always #5 clk = ~clk;

  pdm_cic_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .pdm_clk   (pdm_clk),
    .pdm_in    (pdm_in),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  // Source changes its bit on the rising bit clock, like a PDM microphone.
  always @(posedge pdm_clk) begin
    case (mode)
      0: pdm_in = 1'b0;
      1: pdm_in = 1'b1;
      2: pdm_in = bit_idx[0];
      default: pdm_in = (bit_idx[1:0] == 2'd0);
    endcase
    bit_idx++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (pcm_valid !== 1'b1 && c < 4000) begin
      tick(1);
      c++;
    end
  endtask

  task automatic restart(input int m, input logic rdy, output int l);
    en = 1'b0;
    tick(2);
    mode = m;
    pcm_ready = rdy;
    en = 1'b1;
    wait_valid(l);
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(pcm_valid), 0);
    check("rst_data", 32'(pcm_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_pdm_clk", 32'(pdm_clk), 0);
    reset_n = 1'b1;
    tick(2);

    // Constant ones: full-scale positive, latency and output period.
    restart(1, 1'b1, lat);
    check("lat_ones", lat, 2050);
    check("data_ones", 32'($signed(pcm_data)), 32767);
    tick(1);
    check("accept_clears", 32'(pcm_valid), 0);
    wait_valid(cyc);
    check("valid_period", cyc, 511);
    check("data_ones_2", 32'($signed(pcm_data)), 32767);

    cyc = 0;
    while (pdm_clk !== 1'b0 && cyc < 20) begin tick(1); cyc++; end
    while (pdm_clk !== 1'b1 && cyc < 40) begin tick(1); cyc++; end
    hi = 0;
    while (pdm_clk === 1'b1 && hi < 20) begin tick(1); hi++; end
    lo = 0;
    while (pdm_clk === 1'b0 && lo < 20) begin tick(1); lo++; end
    check("pdm_clk_high", hi, 4);
    check("pdm_clk_low", lo, 4);

    restart(0, 1'b1, lat);
    check("lat_zeros", lat, 2050);
    check("data_zeros", 32'($signed(pcm_data)), -32768);

    restart(2, 1'b1, lat);
    check("data_alt", 32'($signed(pcm_data)), 0);

    restart(3, 1'b1, lat);
    d = 32'($signed(pcm_data)) + 16384;
    check("data_quarter", (d >= -1 && d <= 1) ? 1 : 0, 1);

    // Overrun: consumer stalls across several output periods.
    restart(1, 1'b0, lat);
    check("ovr_first", 32'($signed(pcm_data)), 32767);
    mode = 0;
    tick(511);
    check("ovr_before", 32'(overrun), 0);
    check("data_stable", 32'($signed(pcm_data)), 32767);
    tick(1);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_valid", 32'(pcm_valid), 1);
    tick(1536);
    check("ovr_overwritten", 32'($signed(pcm_data)), -32768);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);
    tick(510);
    pcm_ready = 1'b1;
    tick(1);
    check("ready_on_load_ovr", 32'(overrun), 0);
    check("ready_on_load_valid", 32'(pcm_valid), 1);
    tick(1);
    check("ready_on_load_accept", 32'(pcm_valid), 0);

    // Drop enable mid-frame with an unread sample pending.
    pcm_ready = 1'b0;
    wait_valid(cyc);
    check("pre_drop_valid", 32'(pcm_valid), 1);
    tick(200);
    en = 1'b0;
    tick(1);
    check("drop_pdm_clk", 32'(pdm_clk), 0);
    check("drop_valid", 32'(pcm_valid), 0);
    check("drop_data_held", 32'($signed(pcm_data)), -32768);
    tick(600);
    check("drop_no_sample", 32'(pcm_valid), 0);
    mode = 1;
    en = 1'b1;
    wait_valid(lat);
    check("lat_reenable", lat, 2050);
    check("data_reenable", 32'($signed(pcm_data)), 32767);

    // Asynchronous reset pulse mid-frame.
    tick(300);
    reset_n = 1'b0;
    tick(1);
    check("rstp_pdm_clk", 32'(pdm_clk), 0);
    check("rstp_valid", 32'(pcm_valid), 0);
    check("rstp_data", 32'(pcm_data), 0);
    reset_n = 1'b1;
    pcm_ready = 1'b1;
    wait_valid(lat);
    check("lat_after_reset", lat, 2050);
    check("data_after_reset", 32'($signed(pcm_data)), 32767);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
